// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM for the show-ahead FIFO.
// One write port and one read port, each with its own address. The read
// is registered with a read enable, so the output holds whenever rd_en is
// low. A read and a write to the same address in the same cycle return the
// old contents. Storage and read data are not reset.
module sc_fifo_ram #(
    parameter int ADDR_W = 5,
    parameter int WIDTH  = 20
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_r;

    // Write port: store the word at wr_addr when enabled.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: registered read, holding its value while rd_en is low.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sc_showahead_fifo.sv
// Single-clock show-ahead FIFO.
// Words pass from the RAM through a one-cycle registered read stage
// (pend_r) into the output register that drives q (valid_r). The RAM read
// is issued only when the stage it fills will be free at the next edge.
// This keeps one word per cycle flowing under back-to-back rdreq.
// cnt_r counts every stored word: RAM, pending stage and q.
// mem_cnt_r counts only the words still in the RAM.
module sc_showahead_fifo #(
    parameter int LOG_DEPTH               = 5,
    parameter int WIDTH                   = 20,
    parameter int ALMOST_FULL_VALUE       = 30,
    parameter int ALMOST_EMPTY_VALUE      = 2,
    parameter int OVERFLOW_CHECKING       = 0,
    parameter int UNDERFLOW_CHECKING      = 0,
    parameter int ALLOW_RWCYCLE_WHEN_FULL = 0
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 sclr,
    input  logic [WIDTH-1:0]     data,
    input  logic                 wrreq,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic [LOG_DEPTH-1:0] usedw,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full
);

    localparam int CW = LOG_DEPTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << LOG_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_VALUE);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_VALUE);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_nxt_s;
    logic [CW-1:0]        mem_cnt_r;
    logic [CW-1:0]        mem_cnt_nxt_s;
    logic [LOG_DEPTH-1:0] wr_ptr_r;
    logic [LOG_DEPTH-1:0] rd_ptr_r;
    logic                 pend_r;
    logic                 pend_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;
    logic                 empty_r;
    logic                 full_r;
    logic                 af_r;
    logic                 ae_r;
    logic [WIDTH-1:0]     q_r;
    logic [WIDTH-1:0]     ram_rd_data_s;
    logic                 wr_ok_s;
    logic                 rd_ok_s;
    logic                 load_out_s;
    logic                 prefetch_s;
    logic                 ram_wr_en_s;
    logic                 ram_rd_en_s;

    // Request qualification, pipeline moves and next counts.
    always_comb begin
        rd_ok_s       = 1'b0;
        wr_ok_s       = 1'b0;
        load_out_s    = 1'b0;
        prefetch_s    = 1'b0;
        cnt_nxt_s     = cnt_r;
        mem_cnt_nxt_s = mem_cnt_r;
        pend_nxt_s    = pend_r;
        valid_nxt_s   = valid_r;

        // A pop never takes effect before its word is on q.
        if (UNDERFLOW_CHECKING != 0) begin
            rd_ok_s = rdreq & ~empty_r;
        end else begin
            rd_ok_s = rdreq & valid_r;
        end

        if (OVERFLOW_CHECKING != 0) begin
            if (ALLOW_RWCYCLE_WHEN_FULL != 0) begin
                wr_ok_s = wrreq & (~full_r | rd_ok_s);
            end else begin
                wr_ok_s = wrreq & ~full_r;
            end
        end else begin
            wr_ok_s = wrreq;
        end

        // The pending word moves to q when q is free or is being popped.
        load_out_s = pend_r & (~valid_r | rd_ok_s);
        // Issue a RAM read only if the pending stage is free at the next edge.
        prefetch_s = (mem_cnt_r != {CW{1'b0}}) & (~pend_r | load_out_s);

        case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - ONE_C;
            default: cnt_nxt_s = cnt_r;
        endcase

        case ({wr_ok_s, prefetch_s})
            2'b10:   mem_cnt_nxt_s = mem_cnt_r + ONE_C;
            2'b01:   mem_cnt_nxt_s = mem_cnt_r - ONE_C;
            default: mem_cnt_nxt_s = mem_cnt_r;
        endcase

        if (prefetch_s) begin
            pend_nxt_s = 1'b1;
        end else if (load_out_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end

        if (load_out_s) begin
            valid_nxt_s = 1'b1;
        end else if (rd_ok_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Keep the RAM idle in a clear cycle, so nothing from it survives.
    assign ram_wr_en_s = wr_ok_s & ~sclr;
    assign ram_rd_en_s = prefetch_s & ~sclr;

    sc_fifo_ram #(
        .ADDR_W (LOG_DEPTH),
        .WIDTH  (WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data),
        .rd_en   (ram_rd_en_s),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_rd_data_s)
    );

    // Control state: pointers, counts, pipeline valids and registered flags.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt_r     <= {CW{1'b0}};
            mem_cnt_r <= {CW{1'b0}};
            wr_ptr_r  <= {LOG_DEPTH{1'b0}};
            rd_ptr_r  <= {LOG_DEPTH{1'b0}};
            pend_r    <= 1'b0;
            valid_r   <= 1'b0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            af_r      <= 1'b0;
            ae_r      <= 1'b1;
        end else if (sclr) begin
            cnt_r     <= {CW{1'b0}};
            mem_cnt_r <= {CW{1'b0}};
            wr_ptr_r  <= {LOG_DEPTH{1'b0}};
            rd_ptr_r  <= {LOG_DEPTH{1'b0}};
            pend_r    <= 1'b0;
            valid_r   <= 1'b0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            af_r      <= 1'b0;
            ae_r      <= 1'b1;
        end else begin
            cnt_r     <= cnt_nxt_s;
            mem_cnt_r <= mem_cnt_nxt_s;
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
            end
            if (prefetch_s) begin
                rd_ptr_r <= rd_ptr_r + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
            end
            pend_r    <= pend_nxt_s;
            valid_r   <= valid_nxt_s;
            empty_r   <= ~valid_nxt_s;
            full_r    <= (cnt_nxt_s == DEPTH_C);
            af_r      <= (cnt_nxt_s >= AF_C);
            ae_r      <= (cnt_nxt_s < AE_C);
        end
    end

    // Output data register. It is not reset, because q is don't-care while empty.
    always_ff @(posedge clock) begin
        if (load_out_s) begin
            q_r <= ram_rd_data_s;
        end
    end

    assign q            = q_r;
    assign usedw        = cnt_r[LOG_DEPTH-1:0];
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = ae_r;
    assign almost_full  = af_r;

endmodule

// File: tb/tb_sc_showahead_fifo.sv
// Directed bench for sc_showahead_fifo.
// dut uses the default parameters.
// dut2 enables overflow and underflow checking, and allows a read+write
// cycle while full.
module tb_sc_showahead_fifo;

    logic        clock;
    logic        aclr_n;
    logic        sclr, sclr2;
    logic [19:0] data, data2;
    logic        wrreq, rdreq, wrreq2, rdreq2;
    logic [19:0] q, q2;
    logic [4:0]  usedw, usedw2;
    logic        empty, full, almost_empty, almost_full;
    logic        empty2, full2, almost_empty2, almost_full2;

    int errors = 0;
    int checks = 0;

    sc_showahead_fifo dut (
        .clock        (clock),
        .aclr_n       (aclr_n),
        .sclr         (sclr),
        .data         (data),
        .wrreq        (wrreq),
        .rdreq        (rdreq),
        .q            (q),
        .usedw        (usedw),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full)
    );

    sc_showahead_fifo #(
        .OVERFLOW_CHECKING       (1),
        .UNDERFLOW_CHECKING      (1),
        .ALLOW_RWCYCLE_WHEN_FULL (1)
    ) dut2 (
        .clock        (clock),
        .aclr_n       (aclr_n),
        .sclr         (sclr2),
        .data         (data2),
        .wrreq        (wrreq2),
        .rdreq        (rdreq2),
        .q            (q2),
        .usedw        (usedw2),
        .empty        (empty2),
        .full         (full2),
        .almost_empty (almost_empty2),
        .almost_full  (almost_full2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aclr_n = 1'b0;
        sclr = 1'b0;
        sclr2 = 1'b0;
        data = 20'h0;
        data2 = 20'h0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        wrreq2 = 1'b0;
        rdreq2 = 1'b0;
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_usedw", 32'(usedw), 32'd0);
        aclr_n = 1'b1;
        tick();

        // Single write: visible two edges later.
        data = 20'hABCDE;
        wrreq = 1'b1;
        tick();
        wrreq = 1'b0;
        chk("lat_empty_n", 32'(empty), 32'd1);
        chk("lat_usedw_n", 32'(usedw), 32'd1);
        tick();
        chk("lat_empty_n1", 32'(empty), 32'd1);
        tick();
        chk("lat_empty_n2", 32'(empty), 32'd0);
        chk("lat_q_n2", 32'(q), 32'hABCDE);
        chk("ae_cnt1", 32'(almost_empty), 32'd1);
        data = 20'h12345;
        wrreq = 1'b1;
        tick();
        wrreq = 1'b0;
        chk("ae_cnt2", 32'(almost_empty), 32'd0);
        chk("usedw_cnt2", 32'(usedw), 32'd2);
        tick();
        tick();
        chk("pop1_q", 32'(q), 32'hABCDE);
        rdreq = 1'b1;
        tick();
        chk("pop2_q", 32'(q), 32'h12345);
        chk("pop2_empty", 32'(empty), 32'd0);
        tick();
        rdreq = 1'b0;
        chk("pop_done_empty", 32'(empty), 32'd1);
        chk("pop_done_usedw", 32'(usedw), 32'd0);

        // Fill to 32 words, then drain back to back.
        for (int i = 0; i < 32; i++) begin
            data = 20'(i);
            wrreq = 1'b1;
            tick();
            chk("fill_afull", 32'(almost_full), ((i + 1) >= 30) ? 32'd1 : 32'd0);
        end
        wrreq = 1'b0;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_usedw_wrap", 32'(usedw), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("drain_q", 32'(q), 32'(i));
            chk("drain_empty", 32'(empty), 32'd0);
            rdreq = 1'b1;
            tick();
        end
        rdreq = 1'b0;
        chk("drain_done_empty", 32'(empty), 32'd1);
        chk("drain_done_full", 32'(full), 32'd0);
        chk("drain_done_usedw", 32'(usedw), 32'd0);

        // Fill 10 words, then read and write together for 50 cycles.
        for (int i = 0; i < 10; i++) begin
            data = 20'(100 + i);
            wrreq = 1'b1;
            tick();
        end
        wrreq = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 50; i++) begin
            chk("rw_q", 32'(q), 32'(100 + i));
            data = 20'(110 + i);
            wrreq = 1'b1;
            rdreq = 1'b1;
            tick();
            chk("rw_usedw", 32'(usedw), 32'd10);
        end
        wrreq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("rw_tail_q", 32'(q), 32'(150 + i));
            rdreq = 1'b1;
            tick();
        end
        rdreq = 1'b0;
        chk("rw_tail_empty", 32'(empty), 32'd1);

        // Synchronous clear, taking priority over a write in the same cycle.
        for (int i = 1; i <= 5; i++) begin
            data = 20'(i);
            wrreq = 1'b1;
            tick();
        end
        wrreq = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_sclr_empty", 32'(empty), 32'd0);
        sclr = 1'b1;
        data = 20'h00099;
        wrreq = 1'b1;
        tick();
        sclr = 1'b0;
        wrreq = 1'b0;
        chk("sclr_empty", 32'(empty), 32'd1);
        chk("sclr_usedw", 32'(usedw), 32'd0);
        chk("sclr_aempty", 32'(almost_empty), 32'd1);
        chk("sclr_full", 32'(full), 32'd0);
        data = 20'h00321;
        wrreq = 1'b1;
        tick();
        wrreq = 1'b0;
        chk("post_sclr_usedw", 32'(usedw), 32'd1);
        tick();
        tick();
        chk("post_sclr_q", 32'(q), 32'h00321);
        chk("post_sclr_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 4; i++) begin
            data = 20'(i);
            wrreq = 1'b1;
            tick();
        end
        wrreq = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        #2;
        aclr_n = 1'b0;
        #1;
        chk("aclr_empty", 32'(empty), 32'd1);
        chk("aclr_usedw", 32'(usedw), 32'd0);
        chk("aclr_aempty", 32'(almost_empty), 32'd1);
        #2;
        aclr_n = 1'b1;
        data = 20'h00777;
        wrreq = 1'b1;
        tick();
        wrreq = 1'b0;
        chk("post_aclr_usedw", 32'(usedw), 32'd1);
        tick();
        tick();
        chk("post_aclr_q", 32'(q), 32'h00777);
        chk("post_aclr_empty", 32'(empty), 32'd0);

        // dut2: write while full is blocked, unless the same cycle also reads.
        for (int i = 0; i < 32; i++) begin
            data2 = 20'(200 + i);
            wrreq2 = 1'b1;
            tick();
        end
        wrreq2 = 1'b0;
        tick();
        tick();
        tick();
        chk("ov_full", 32'(full2), 32'd1);
        chk("ov_q_head", 32'(q2), 32'd200);
        data2 = 20'hFFFFF;
        wrreq2 = 1'b1;
        tick();
        wrreq2 = 1'b0;
        chk("ov_blocked_full", 32'(full2), 32'd1);
        chk("ov_blocked_usedw", 32'(usedw2), 32'd0);
        chk("ov_blocked_q", 32'(q2), 32'd200);
        data2 = 20'h55555;
        wrreq2 = 1'b1;
        rdreq2 = 1'b1;
        tick();
        wrreq2 = 1'b0;
        rdreq2 = 1'b0;
        chk("rwfull_full", 32'(full2), 32'd1);
        chk("rwfull_usedw", 32'(usedw2), 32'd0);
        for (int i = 0; i < 32; i++) begin
            chk("ov_drain_q", 32'(q2), (i < 31) ? 32'(201 + i) : 32'h55555);
            rdreq2 = 1'b1;
            tick();
        end
        chk("ov_drain_empty", 32'(empty2), 32'd1);
        chk("ov_drain_full", 32'(full2), 32'd0);
        tick();
        chk("uf_usedw", 32'(usedw2), 32'd0);
        chk("uf_empty", 32'(empty2), 32'd1);
        data2 = 20'h00ABC;
        wrreq2 = 1'b1;
        tick();
        wrreq2 = 1'b0;
        chk("uf_wr_usedw", 32'(usedw2), 32'd1);
        tick();
        tick();
        chk("uf_wr_q", 32'(q2), 32'h00ABC);
        chk("uf_wr_empty", 32'(empty2), 32'd0);
        rdreq2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
